// File: rtl/prio_dec_pkg.sv
// Shared types and constants for the priority-code receive path.
package prio_dec_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ONEHOT_W = 15;
  localparam int unsigned SYNC_W   = 7;

  localparam int unsigned CODE_LSB = 0;
  localparam int unsigned STRB_BIT = 4;
  localparam int unsigned NONE_BIT = 5;
  localparam int unsigned CLR_BIT  = 6;
  localparam int unsigned HOLD_BIT = 7;

  localparam logic [CODE_W-1:0] ILLEGAL_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] code;
  } entry_t;

  // A none entry still occupies a slot but drives nothing.
  function automatic logic [ONEHOT_W-1:0] decode(entry_t e);
    return e.none ? '0 : (ONEHOT_W'(1) << e.code);
  endfunction

endpackage

// File: rtl/prio_dec_fifo.sv
// Small code queue: flush wins, a push while full only lands if a pop frees a slot on the same edge.
module prio_dec_fifo
  import prio_dec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head_c,
  output logic   empty_c,
  output logic   full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // An empty FIFO never pops, so a simultaneous push is not bypassed.
  always_comb begin
    do_pop    = pop && !empty_c;
    do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Receive side of the priority-encoder link: sync, strobe edge, queue, one-hot sequencer.
module tt_um_priority_decoder
  import prio_dec_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [SYNC_W-1:0]   sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0]   synced;
  logic                strb_q;
  logic                clr_s;
  logic                hold;
  logic                push_c;
  logic                pop_c;
  entry_t              push_entry;
  entry_t              head_c;
  logic                empty_c;
  logic                fifo_full;
  seq_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [ONEHOT_W-1:0] onehot;
  logic                unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in};

  assign synced = sync_q[SYNC_STAGES-1];
  assign clr_s  = synced[CLR_BIT];
  assign hold   = ui_in[HOLD_BIT];

  // Edge state keeps tracking strb through clr, so a held strb is not re-pushed on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      strb_q <= 1'b0;
    end else begin
      sync_q[0] <= ui_in[SYNC_W-1:0];
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      strb_q <= synced[STRB_BIT];
    end
  end

  always_comb begin
    push_entry.code = synced[CODE_LSB +: CODE_W];
    push_entry.none = synced[NONE_BIT] | (synced[CODE_LSB +: CODE_W] == ILLEGAL_CODE);
    push_c          = synced[STRB_BIT] & ~strb_q & ~clr_s;
    pop_c           = (state == IDLE) & ~empty_c & ~clr_s;
  end

  prio_dec_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clr_s),
    .push     (push_c),
    .push_data(push_entry),
    .pop      (pop_c),
    .head_c   (head_c),
    .empty_c  (empty_c),
    .full     (fifo_full)
  );

  // Sequencer: PULSE_LEN cycles (or held) high, one GAP cycle low, one IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      onehot <= '0;
    end else if (clr_s) begin
      state  <= IDLE;
      cnt    <= '0;
      onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty_c) begin
            onehot <= decode(head_c);
            cnt    <= CNT_W'(PULSE_LEN - 1);
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold) begin
            if (!empty_c) begin
              onehot <= '0;
              state  <= GAP;
            end
          end else if (cnt == '0) begin
            onehot <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = {fifo_full, onehot[14:8]};
  assign uio_out = onehot[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Bench for tt_um_priority_decoder: timestamp-based slot model plus pinned literal expectations.
module tb_tt_um_priority_decoder;

  localparam int P   = 4;
  localparam int D   = 4;
  localparam int INF = 1 << 30;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_priority_decoder #(
    .PULSE_LEN  (4),
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: queued codes (-1 = empty slot), current output slot timing, pin history.
  int          q[$];
  logic [14:0] m_onehot = '0;
  logic        m_full   = 1'b0;
  bit          driving  = 1'b0;
  int          off_at   = INF;
  int          next_ok  = 0;
  logic [6:0]  h1 = '0, h2 = '0, h3 = '0;

  typedef struct {
    int         at;
    logic [7:0] uo;
    logic [7:0] uio;
    string      name;
  } lit_t;
  lit_t lits[$];

  task automatic check(input string name, input logic [7:0] uo_a, input logic [7:0] uio_a,
                       input logic [7:0] oe_a, input logic [7:0] uo_e, input logic [7:0] uio_e);
    n_checks++;
    if (uo_a === uo_e && uio_a === uio_e && oe_a === 8'hFF) n_pass++;
    else $display("FAIL %s cycle %0d: got uo_out=%h uio_out=%h uio_oe=%h, need uo_out=%h uio_out=%h uio_oe=ff",
                  name, cyc, uo_a, uio_a, oe_a, uo_e, uio_e);
  endtask

  task automatic expect_at(input int at, input logic [7:0] uo, input logic [7:0] uio, input string name);
    lit_t l;
    l.at = at; l.uo = uo; l.uio = uio; l.name = name;
    lits.push_back(l);
  endtask

  task automatic model_reset();
    q.delete();
    m_onehot = '0;
    m_full   = 1'b0;
    driving  = 1'b0;
    off_at   = INF;
    next_ok  = 0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  // Pin sampled at edge n-2 acts at edge n; one slot = PULSE_LEN high (or until queue non-empty in hold), then 2 low.
  task automatic model_step();
    int pre;
    int e;
    bit popped;
    popped = 1'b0;
    pre = q.size();
    if (h2[6]) begin
      q.delete();
      m_onehot = '0;
      driving  = 1'b0;
      next_ok  = cyc + 1;
    end else begin
      if (driving && ui_in[7] && off_at == INF && pre > 0) off_at = cyc;
      if (driving && cyc == off_at) begin
        m_onehot = '0;
        driving  = 1'b0;
        next_ok  = cyc + 2;
      end else if (!driving && cyc >= next_ok && pre > 0) begin
        e = q.pop_front();
        m_onehot = '0;
        if (e >= 0) m_onehot[e] = 1'b1;
        driving = 1'b1;
        off_at  = ui_in[7] ? INF : cyc + P;
        popped  = 1'b1;
      end
      if (h2[4] && !h3[4]) begin
        e = (h2[5] || h2[3:0] == 4'hF) ? -1 : int'(h2[3:0]);
        if (pre < D || popped) q.push_back(e);
      end
    end
    m_full = (q.size() == D);
    h3 = h2; h2 = h1; h1 = ui_in[6:0];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (clk) cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("model", uo_out, uio_out, uio_oe, {m_full, m_onehot[14:8]}, m_onehot[7:0]);
    if (clk) begin
      for (int i = lits.size() - 1; i >= 0; i--) begin
        if (lits[i].at == cyc) begin
          check(lits[i].name, uo_out, uio_out, uio_oe, lits[i].uo, lits[i].uio);
          lits.delete(i);
        end
      end
    end
  end

  // Code stable one cycle before strb and through edge k+2; k is the edge that first samples strb.
  task automatic send(input logic [3:0] c, input logic nn, output int k);
    @(negedge clk); ui_in[3:0] = c; ui_in[5] = nn;
    @(negedge clk); ui_in[4] = 1'b1; k = cyc + 1;
    @(negedge clk); ui_in[4] = 1'b0;
    @(negedge clk);
  endtask

  // Back-to-back strobe every 2 cycles, code changing together with strb.
  task automatic fast(input logic [3:0] c, output int k);
    @(negedge clk); ui_in[3:0] = c; ui_in[5] = 1'b0; ui_in[4] = 1'b1; k = cyc + 1;
    @(negedge clk); ui_in[4] = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k, k0, c;
    logic [3:0] burst [7];
    logic [3:0] clr_burst [5];
    burst     = '{4'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8};
    clr_burst = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

    repeat (3) @(negedge clk);
    check("reset", uo_out, uio_out, uio_oe, 8'h00, 8'h00);
    rst_n = 1'b1;
    idle(4);

    // T1: single code 9, pulse mode
    send(4'h9, 1'b0, k);
    expect_at(k + 2, 8'h00, 8'h00, "t1_before");
    expect_at(k + 3, 8'h02, 8'h00, "t1_first");
    expect_at(k + 6, 8'h02, 8'h00, "t1_last");
    expect_at(k + 7, 8'h00, 8'h00, "t1_off");
    idle(14);

    // T2: codes 0, 14, 5 back to back, 6-cycle slot spacing
    send(4'h0, 1'b0, k0);
    expect_at(k0 + 3,  8'h00, 8'h01, "t2_code0");
    expect_at(k0 + 8,  8'h00, 8'h00, "t2_gap0");
    expect_at(k0 + 9,  8'h40, 8'h00, "t2_code14");
    expect_at(k0 + 12, 8'h40, 8'h00, "t2_code14_end");
    expect_at(k0 + 14, 8'h00, 8'h00, "t2_gap14");
    expect_at(k0 + 15, 8'h00, 8'h20, "t2_code5");
    send(4'hE, 1'b0, k);
    send(4'h5, 1'b0, k);
    idle(20);

    // T4: none slot, illegal code slot, then code 3
    send(4'h5, 1'b1, k0);
    expect_at(k0 + 3,  8'h00, 8'h00, "t4_none_slot");
    expect_at(k0 + 14, 8'h00, 8'h00, "t4_before3");
    expect_at(k0 + 15, 8'h00, 8'h08, "t4_code3");
    expect_at(k0 + 19, 8'h00, 8'h00, "t4_off3");
    send(4'hF, 1'b0, k);
    send(4'h3, 1'b0, k);
    idle(16);

    // T3: 7 rapid codes; first occupies output, 4 queue, last dropped
    fast(burst[0], k0);
    expect_at(k0 + 3,  8'h04, 8'h00, "t3_code10");
    expect_at(k0 + 12, 8'h80, 8'h02, "t3_full_code1");
    expect_at(k0 + 14, 8'h80, 8'h00, "t3_full_drop");
    expect_at(k0 + 15, 8'h00, 8'h04, "t3_code2");
    expect_at(k0 + 33, 8'h00, 8'h40, "t3_code6");
    expect_at(k0 + 39, 8'h00, 8'h00, "t3_no_code8");
    expect_at(k0 + 45, 8'h00, 8'h00, "t3_quiet");
    for (int i = 1; i < 7; i++) fast(burst[i], k);
    wait_edge(k0 + 50);

    // T5: hold mode, code 7 held until code 2 arrives
    @(negedge clk); ui_in[7] = 1'b1;
    idle(2);
    send(4'h7, 1'b0, k);
    expect_at(k + 3,  8'h00, 8'h80, "t5_hold7");
    expect_at(k + 20, 8'h00, 8'h80, "t5_hold7_late");
    wait_edge(k + 22);
    send(4'h2, 1'b0, k);
    expect_at(k + 2,  8'h00, 8'h80, "t5_still7");
    expect_at(k + 3,  8'h00, 8'h00, "t5_gap");
    expect_at(k + 5,  8'h00, 8'h04, "t5_code2");
    expect_at(k + 15, 8'h00, 8'h04, "t5_hold2");
    wait_edge(k + 16);
    @(negedge clk); ui_in[6] = 1'b1; c = cyc;
    expect_at(c + 3, 8'h00, 8'h00, "t5_clr");
    idle(6);
    ui_in[7] = 1'b0;
    idle(2);
    ui_in[6] = 1'b0;
    idle(6);

    // T6: clr with 3 entries queued mid-DRIVE, strb held across release
    fast(clr_burst[0], k0);
    expect_at(k0 + 11, 8'h00, 8'h04, "t6_code2");
    expect_at(k0 + 12, 8'h00, 8'h00, "t6_clr_zero");
    for (int i = 1; i < 5; i++) fast(clr_burst[i], k);
    @(negedge clk); ui_in[6] = 1'b1; ui_in[3:0] = 4'h9; ui_in[4] = 1'b1;
    wait_edge(k0 + 20);
    @(negedge clk); ui_in[6] = 1'b0; c = cyc;
    expect_at(c + 10, 8'h00, 8'h00, "t6_no_stale");
    expect_at(c + 25, 8'h00, 8'h00, "t6_no_repush");
    idle(4);
    ui_in[4] = 1'b0;
    wait_edge(c + 26);

    // T6: async reset mid-DRIVE, then recovery
    send(4'hB, 1'b0, k);
    expect_at(k + 3, 8'h08, 8'h00, "t6_code11");
    wait_edge(k + 4);
    #5;
    rst_n = 1'b0;
    #2;
    check("rst_async", uo_out, uio_out, uio_oe, 8'h00, 8'h00);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    send(4'hC, 1'b0, k);
    expect_at(k + 3, 8'h10, 8'h00, "post_rst_code12");
    expect_at(k + 7, 8'h00, 8'h00, "post_rst_off");
    wait_edge(k + 10);

    foreach (lits[i]) begin
      n_checks++;
      $display("FAIL %s: expected cycle %0d never reached (now %0d)", lits[i].name, lits[i].at, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
